dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 256x32 data memory, letting a primary requester (port 0, CPU load/store stage) and a secondary requester (port 1, debug/loader) share it. Accepts at most one access per cycle and drives the memory's read address, write address, write data, write enable and clock enable. For each port, captures read data into a one-entry response buffer with valid/ready backpressure. Sits between the pipeline/debug logic and the data memory instance.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_rsp_slot.sv | 50 +++++
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: default widths,
// port indices and the response-slot state encoding.
package dmem_arb_pkg;

  localparam int AW_DEF = 8;   // 256-word data memory
  localparam int DW_DEF = 32;

  localparam int PORT_CPU = 0;  // load/store stage, favoured by fixed priority
  localparam int PORT_DBG = 1;  // debug / loader

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/dmem_rsp_slot.sv
// One-entry response buffer for a single arbiter port.
// load = a read was accepted this cycle (data arrives on load_data),
// pop  = the consumer takes the current entry (rsp_ready).
// load and pop may coincide: the old entry leaves and the new one replaces it.
// Everything is frozen while en=0. The state output doubles as debug visibility.
module dmem_rsp_slot
  import dmem_arb_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load,
  input  logic          pop,
  input  logic [DW-1:0] load_data,
  output rsp_state_t    state,
  output logic [DW-1:0] data
);

  rsp_state_t state_next;

  // State register; reset empties the slot immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RSP_EMPTY;
    else        state <= state_next;
  end

  // Next state: a load always leaves the slot full; a pop without load empties it.
  always_comb begin
    state_next = state;
    if (en) begin
      case (state)
        RSP_EMPTY: if (load) state_next = RSP_FULL;
        RSP_FULL: begin
          if (load)     state_next = RSP_FULL;
          else if (pop) state_next = RSP_EMPTY;
        end
        default: state_next = RSP_EMPTY;
      endcase
    end
  end

  // Data register captures memory read data on every accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           data <= '0;
    else if (en && load)  data <= load_data;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 256x32 data memory.
// Port 0 (CPU) and port 1 (debug) share one access per cycle; reads return
// through a per-port one-entry response slot.
// Handshake: a request transfers on a rising edge where req_valid & req_ready;
// a response transfers on a rising edge where rsp_valid & rsp_ready. Valid must
// hold its payload stable until the transfer; ready never depends on the same
// port's valid being asserted for any reason other than arbitration.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration; otherwise
// port 0 has strict priority and there is no pointer register.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          m0_req_valid,
  output logic          m0_req_ready,
  input  logic          m0_req_we,
  input  logic [AW-1:0] m0_req_addr,
  input  logic [DW-1:0] m0_req_wdata,
  output logic          m0_rsp_valid,
  input  logic          m0_rsp_ready,
  output logic [DW-1:0] m0_rsp_data,
  input  logic          m1_req_valid,
  output logic          m1_req_ready,
  input  logic          m1_req_we,
  input  logic [AW-1:0] m1_req_addr,
  input  logic [DW-1:0] m1_req_wdata,
  output logic          m1_rsp_valid,
  input  logic          m1_rsp_ready,
  output logic [DW-1:0] m1_rsp_data,
  output logic [AW-1:0] mem_r_address,
  output logic [AW-1:0] mem_w_address,
  output logic [DW-1:0] mem_w_data,
  output logic          mem_w_enable,
  output logic          mem_clk_enable,
  input  logic [DW-1:0] mem_o_data
);

  logic       live;     // advancing and out of reset: nothing is accepted otherwise
  logic [1:0] elig;
  logic [1:0] grant;
  logic       sel_dbg;
  rsp_state_t rsp_state0;
  rsp_state_t rsp_state1;

  assign live           = en & rst_n;
  assign mem_clk_enable = en;

  assign m0_rsp_valid = (rsp_state0 == RSP_FULL);
  assign m1_rsp_valid = (rsp_state1 == RSP_FULL);

  // A port may compete only if its response slot can take a new entry this cycle.
  assign elig[PORT_CPU] = live & m0_req_valid & (~m0_rsp_valid | m0_rsp_ready);
  assign elig[PORT_DBG] = live & m1_req_valid & (~m1_rsp_valid | m1_rsp_ready);

`ifdef DMEM_ARB_RR_EN
  logic last_dbg;  // 1 = port 1 won the most recent accept

  // Round-robin pointer; only moves when an access is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_dbg <= 1'b1;
    else if (|grant) last_dbg <= grant[PORT_DBG];
  end

  // On contention the port that did not win last time gets the grant.
  always_comb begin
    grant = elig;
    if (elig[PORT_CPU] && elig[PORT_DBG]) begin
      grant           = '0;
      grant[PORT_CPU] = last_dbg;
      grant[PORT_DBG] = ~last_dbg;
    end
  end
`else
  // Fixed priority: port 0 always wins on contention.
  always_comb begin
    grant = '0;
    if (elig[PORT_CPU])      grant[PORT_CPU] = 1'b1;
    else if (elig[PORT_DBG]) grant[PORT_DBG] = 1'b1;
  end
`endif

  assign m0_req_ready = grant[PORT_CPU];
  assign m1_req_ready = grant[PORT_DBG];

  // Memory side follows the winner; idle cycles show port 0's fields.
  assign sel_dbg       = grant[PORT_DBG];
  assign mem_r_address = sel_dbg ? m1_req_addr  : m0_req_addr;
  assign mem_w_address = sel_dbg ? m1_req_addr  : m0_req_addr;
  assign mem_w_data    = sel_dbg ? m1_req_wdata : m0_req_wdata;
  assign mem_w_enable  = (grant[PORT_CPU] & m0_req_we) | (grant[PORT_DBG] & m1_req_we);

  dmem_rsp_slot #(.DW(DW)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (grant[PORT_CPU] & ~m0_req_we),
    .pop       (m0_rsp_ready),
    .load_data (mem_o_data),
    .state     (rsp_state0),
    .data      (m0_rsp_data)
  );

  dmem_rsp_slot #(.DW(DW)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (grant[PORT_DBG] & ~m1_req_we),
    .pop       (m1_rsp_ready),
    .load_data (mem_o_data),
    .state     (rsp_state1),
    .data      (m1_rsp_data)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural 256x32 memory, a directed driver that
// pushes expected read data into per-port queues, and a monitor that pops and
// compares on every response handshake.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        m0_req_valid, m0_req_ready, m0_req_we;
  logic [7:0]  m0_req_addr;
  logic [31:0] m0_req_wdata;
  logic        m0_rsp_valid, m0_rsp_ready;
  logic [31:0] m0_rsp_data;
  logic        m1_req_valid, m1_req_ready, m1_req_we;
  logic [7:0]  m1_req_addr;
  logic [31:0] m1_req_wdata;
  logic        m1_rsp_valid, m1_rsp_ready;
  logic [31:0] m1_rsp_data;
  logic [7:0]  mem_r_address, mem_w_address;
  logic [31:0] mem_w_data;
  logic        mem_w_enable, mem_clk_enable;
  logic [31:0] mem_o_data;

  logic [31:0] mem [256];
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;

`ifdef DMEM_ARB_RR_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_data(m0_rsp_data),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_data(m1_rsp_data),
    .mem_r_address(mem_r_address), .mem_w_address(mem_w_address), .mem_w_data(mem_w_data),
    .mem_w_enable(mem_w_enable), .mem_clk_enable(mem_clk_enable), .mem_o_data(mem_o_data)
  );

  // Clock / memory model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_clk_enable && mem_w_enable) mem[mem_w_address] = mem_w_data;
  end

  assign mem_o_data = mem[mem_r_address];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on a port and wait (bounded) for it to be accepted.
  task automatic do_req(input int port, input logic we, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [31:0] expd);
    bit acc;
    acc = 1'b0;
    if (port == 0) begin
      m0_req_valid = 1'b1; m0_req_we = we; m0_req_addr = addr; m0_req_wdata = wdata;
    end else begin
      m1_req_valid = 1'b1; m1_req_we = we; m1_req_addr = addr; m1_req_wdata = wdata;
    end
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if ((port == 0 && m0_req_ready) || (port == 1 && m1_req_ready)) begin
        acc = 1'b1;
        if (!we) begin
          if (port == 0) exp0_q.push_back(expd);
          else           exp1_q.push_back(expd);
        end
      end
      step();
    end
    chk("req_accept", {31'b0, acc}, 32'd1);
    if (port == 0) m0_req_valid = 1'b0;
    else           m1_req_valid = 1'b0;
    if (!we && acc) chk("rsp_latency", {31'b0, (port == 0) ? m0_rsp_valid : m1_rsp_valid}, 32'd1);
  endtask

  // Monitor: every response handshake must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && en && m0_rsp_valid && m0_rsp_ready) begin
        if (exp0_q.size() == 0) begin
          n_checks++; n_fails++;
          $display("FAIL m0_rsp_extra: got %h expected no response", m0_rsp_data);
        end else chk("m0_rsp_data", m0_rsp_data, exp0_q.pop_front());
      end
      if (rst_n && en && m1_rsp_valid && m1_rsp_ready) begin
        if (exp1_q.size() == 0) begin
          n_checks++; n_fails++;
          $display("FAIL m1_rsp_extra: got %h expected no response", m1_rsp_data);
        end else chk("m1_rsp_data", m1_rsp_data, exp1_q.pop_front());
      end
    end
  end

  // Directed stimulus
  initial begin
    int first;
    int ge;
    rst_n = 1'b0; en = 1'b0;
    m0_req_valid = 0; m0_req_we = 0; m0_req_addr = 0; m0_req_wdata = 0; m0_rsp_ready = 1;
    m1_req_valid = 0; m1_req_we = 0; m1_req_addr = 0; m1_req_wdata = 0; m1_rsp_ready = 1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_m0_valid", {31'b0, m0_rsp_valid}, 32'd0);
    chk("rst_m1_valid", {31'b0, m1_rsp_valid}, 32'd0);
    chk("rst_m0_data", m0_rsp_data, 32'h0);
    chk("rst_m1_data", m1_rsp_data, 32'h0);
    step();
    rst_n = 1'b1;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    @(negedge clk);
    chk("en0_m0_ready", {31'b0, m0_req_ready}, 32'd0);
    chk("en0_m1_ready", {31'b0, m1_req_ready}, 32'd0);
    step();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0; en = 1'b1;

    // Write then read back on port 0
    do_req(0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0);
    do_req(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF);
    chk("rd_back_data", m0_rsp_data, 32'hDEADBEEF);
    do_req(1, 1'b1, 8'h01, 32'h11111111, 32'h0);
    do_req(1, 1'b1, 8'h02, 32'h22222222, 32'h0);
    step();

    // Contention: both ports read every cycle
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 8'h01;
    m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ge = (RR != 0) ? (i % 2) : 0;
      chk("contend_m0_ready", {31'b0, m0_req_ready}, {31'b0, ge == 0});
      chk("contend_m1_ready", {31'b0, m1_req_ready}, {31'b0, ge == 1});
      if (ge == 0) exp0_q.push_back(32'h11111111);
      else         exp1_q.push_back(32'h22222222);
      step();
    end
    m0_req_valid = 0; m1_req_valid = 0;
    repeat (2) step();

    // Backpressure on port 1
    do_req(1, 1'b1, 8'h05, 32'h55AA55AA, 32'h0);
    m1_rsp_ready = 1'b0;
    do_req(1, 1'b0, 8'h05, 32'h0, 32'h55AA55AA);
    m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 8'h02;
    repeat (3) begin
      @(negedge clk);
      chk("bp_m1_ready", {31'b0, m1_req_ready}, 32'd0);
      chk("bp_m1_valid", {31'b0, m1_rsp_valid}, 32'd1);
      chk("bp_m1_hold", m1_rsp_data, 32'h55AA55AA);
      step();
    end
    m1_rsp_ready = 1'b1;
    @(negedge clk);
    chk("b2b_m1_ready", {31'b0, m1_req_ready}, 32'd1);
    exp1_q.push_back(32'h22222222);
    step();
    m1_req_valid = 0;
    chk("b2b_m1_valid", {31'b0, m1_rsp_valid}, 32'd1);
    chk("b2b_m1_data", m1_rsp_data, 32'h22222222);
    repeat (2) step();

    // en=0 freeze with a held response on port 0
    m0_rsp_ready = 1'b0;
    do_req(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF);
    en = 1'b0; m0_rsp_ready = 1'b1;
    m0_req_valid = 1; m0_req_we = 1; m0_req_addr = 8'h20; m0_req_wdata = 32'h12345678;
    m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 8'h01;
    repeat (3) begin
      @(negedge clk);
      chk("frz_m0_ready", {31'b0, m0_req_ready}, 32'd0);
      chk("frz_m1_ready", {31'b0, m1_req_ready}, 32'd0);
      chk("frz_w_enable", {31'b0, mem_w_enable}, 32'd0);
      chk("frz_clk_enable", {31'b0, mem_clk_enable}, 32'd0);
      chk("frz_m0_valid", {31'b0, m0_rsp_valid}, 32'd1);
      chk("frz_m0_data", m0_rsp_data, 32'hDEADBEEF);
      step();
    end
    en = 1'b1;
    first = (RR != 0) ? 1 : 0;
    @(negedge clk);
    chk("resume_m0_ready", {31'b0, m0_req_ready}, {31'b0, first == 0});
    chk("resume_m1_ready", {31'b0, m1_req_ready}, {31'b0, first == 1});
    chk("resume_w_enable", {31'b0, mem_w_enable}, {31'b0, first == 0});
    if (first == 1) exp1_q.push_back(32'h11111111);
    step();
    if (first == 0) m0_req_valid = 0; else m1_req_valid = 0;
    @(negedge clk);
    chk("resume2_m0_ready", {31'b0, m0_req_ready}, {31'b0, first == 1});
    chk("resume2_m1_ready", {31'b0, m1_req_ready}, {31'b0, first == 0});
    if (first == 0) exp1_q.push_back(32'h11111111);
    step();
    m0_req_valid = 0; m1_req_valid = 0;
    do_req(0, 1'b0, 8'h20, 32'h0, 32'h12345678);
    step();

    // Address boundary
    do_req(0, 1'b1, 8'hFF, 32'hCAFEF00D, 32'h0);
    do_req(0, 1'b0, 8'h00, 32'h0, 32'h0);
    do_req(1, 1'b0, 8'hFF, 32'h0, 32'hCAFEF00D);
    repeat (2) step();

    // Asynchronous reset with a pending response
    m0_rsp_ready = 1'b0;
    do_req(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, m0_rsp_valid}, 32'd0);
    chk("async_rst_data", m0_rsp_data, 32'h0);
    exp0_q.delete();
    m0_req_valid = 1; m0_req_we = 1; m0_req_addr = 8'h10; m0_req_wdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rst_no_write", {31'b0, mem_w_enable}, 32'd0);
    chk("rst_no_ready", {31'b0, m0_req_ready}, 32'd0);
    step();
    rst_n = 1'b1; m0_req_valid = 0; m0_rsp_ready = 1'b1;
    step();
    do_req(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF);
    do_req(1, 1'b0, 8'hFF, 32'h0, 32'hCAFEF00D);
    repeat (3) step();

    chk("exp0_drained", exp0_q.size(), 32'd0);
    chk("exp1_drained", exp1_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

endmodule
